// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA prime-search datapath: the candidate
// generator state encoding, the sieve prime table and the remainder width.
package rsa_pkg;

   localparam int REM_W = 6;

   typedef logic [REM_W-1:0] rem_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SIEVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // First 16 odd primes; lane i of the sieve divides by SMALL_PRIMES[i].
   localparam rem_t SMALL_PRIMES [0:15] = '{
      6'd3,  6'd5,  6'd7,  6'd11, 6'd13, 6'd17, 6'd19, 6'd23,
      6'd29, 6'd31, 6'd37, 6'd41, 6'd43, 6'd47, 6'd53, 6'd59
   };

endpackage

// File: rtl/small_prime_rem.sv
// One sieve lane: bit-serial (MSB first) remainder of the candidate modulo a
// constant small prime p. After WIDTH enabled steps rem_o holds cand mod p.
module small_prime_rem
   import rsa_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   input  logic bit_i,
   input  rem_t p_i,
   output rem_t rem_o
);

   logic [REM_W:0] t;
   rem_t           rem_q;
   rem_t           rem_d;

   // Long-division step: t = 2*r + bit, subtract p once if t reached it
   always_comb begin
      t     = {rem_q, bit_i};
      rem_d = rem_q;
      if (clear_i) begin
         rem_d = '0;
      end else if (enable_i) begin
         if (t >= {1'b0, p_i}) begin
            rem_d = rem_t'(t - {1'b0, p_i});
         end else begin
            rem_d = rem_t'(t);
         end
      end
   end

   // Remainder register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem_o = rem_q;

endmodule

// File: rtl/prime_candidate_gen.sv
// Prime candidate generator: pops raw RNG words, forces MSB and LSB to 1,
// trial-divides by the first NUM_SMALL odd primes and forwards survivors
// over a valid/ready handshake.
// Build option: define PRIME_SIEVE_EN to build the trial-division sieve;
// without it every conditioned word is forwarded and rejected_cnt is 0.
module prime_candidate_gen
   import rsa_pkg::*;
#(
   parameter int WIDTH     = 512,
   parameter int NUM_SMALL = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [WIDTH-1:0] rnd_data,
   input  logic             rnd_empty,
   output logic             rnd_rd_en,
   output logic [WIDTH-1:0] cand_data,
   output logic             cand_valid,
   input  logic             cand_ready,
   output logic [15:0]      rejected_cnt
);

   if (WIDTH < 16 || NUM_SMALL < 1 || NUM_SMALL > 16) begin : g_param_err
      $error("prime_candidate_gen: illegal WIDTH or NUM_SMALL");
   end

   // MSB forced so the candidate is full width (and > 59), LSB forced odd.
   localparam logic [WIDTH-1:0] COND_MASK = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

`ifdef PRIME_SIEVE_EN
   localparam state_e POP_NEXT = ST_SIEVE;
`else
   localparam state_e POP_NEXT = ST_OUT;
`endif

   state_e           state_q;
   state_e           state_d;
   logic             pop;
   logic             xfer;
   logic [WIDTH-1:0] word_cond;
   logic [WIDTH-1:0] cand_data_q;
   logic             cand_valid_q;

   assign word_cond = rnd_data | COND_MASK;
   assign pop       = rnd_rd_en;
   assign xfer      = (state_q == ST_OUT) && cand_ready;

`ifdef PRIME_SIEVE_EN
   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0]     cand_q;
   logic [WIDTH-1:0]     shreg_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [15:0]          rej_cnt_q;
   logic                 sieve_en;
   logic                 sieve_last;
   logic                 any_zero;
   logic [NUM_SMALL-1:0] lane_zero;

   assign sieve_en   = (state_q == ST_SIEVE);
   assign sieve_last = (cnt_q == CNT_W'(WIDTH - 1));
   assign any_zero   = |lane_zero;

   for (genvar i = 0; i < NUM_SMALL; i++) begin : g_lane
      rem_t rem;
      small_prime_rem u_rem (
         .clk_i    (aclk),
         .rst_ni   (aresetn),
         .clear_i  (pop),
         .enable_i (sieve_en),
         .bit_i    (shreg_q[WIDTH-1]),
         .p_i      (SMALL_PRIMES[i]),
         .rem_o    (rem)
      );
      assign lane_zero[i] = (rem == '0);
   end

   // Capture the candidate, shift it out MSB first and count sieve steps
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cand_q  <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (pop) begin
         cand_q  <= word_cond;
         shreg_q <= word_cond;
         cnt_q   <= '0;
      end else if (sieve_en) begin
         shreg_q <= shreg_q << 1;
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   // Count candidates that a small prime divides (wraps at 16 bits)
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rej_cnt_q <= '0;
      end else if (state_q == ST_CHECK && any_zero) begin
         rej_cnt_q <= rej_cnt_q + 16'd1;
      end
   end

   assign rejected_cnt = rej_cnt_q;

   // Load the output register when a candidate survives the sieve
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cand_data_q  <= '0;
         cand_valid_q <= 1'b0;
      end else if (state_q == ST_CHECK && !any_zero) begin
         cand_data_q  <= cand_q;
         cand_valid_q <= 1'b1;
      end else if (xfer) begin
         cand_valid_q <= 1'b0;
      end
   end
`else
   assign rejected_cnt = 16'd0;

   // Load the output register directly from the popped, conditioned word
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cand_data_q  <= '0;
         cand_valid_q <= 1'b0;
      end else if (pop) begin
         cand_data_q  <= word_cond;
         cand_valid_q <= 1'b1;
      end else if (xfer) begin
         cand_valid_q <= 1'b0;
      end
   end
`endif

   assign cand_data  = cand_data_q;
   assign cand_valid = cand_valid_q;

   // FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!rnd_empty) state_d = POP_NEXT;
`ifdef PRIME_SIEVE_EN
         ST_SIEVE: if (sieve_last) state_d = ST_CHECK;
         ST_CHECK: state_d = any_zero ? ST_IDLE : ST_OUT;
`endif
         ST_OUT:   if (cand_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: pop the FIFO in the same cycle a word is accepted in IDLE
   always_comb begin
      rnd_rd_en = aresetn && (state_q == ST_IDLE) && !rnd_empty;
   end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Bench for prime_candidate_gen at WIDTH=16. Expected candidates are queued
// when a word is popped; a monitor compares them at each handshake transfer.
`timescale 1ns/1ps
module tb_prime_candidate_gen;

   localparam int W = 16;
`ifdef PRIME_SIEVE_EN
   localparam bit SIEVE = 1'b1;
`else
   localparam bit SIEVE = 1'b0;
`endif
   localparam int LAT = SIEVE ? W + 2 : 1;

   logic          clk;
   logic          aresetn;
   logic [W-1:0]  rnd_data;
   logic          rnd_empty;
   logic          rnd_rd_en;
   logic [W-1:0]  cand_data;
   logic          cand_valid;
   logic          cand_ready;
   logic [15:0]   rejected_cnt;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [W-1:0]  exp_q [$];
   int            exp_rej = 0;

   prime_candidate_gen #(.WIDTH(W), .NUM_SMALL(16)) dut (
      .aclk         (clk),
      .aresetn      (aresetn),
      .rnd_data     (rnd_data),
      .rnd_empty    (rnd_empty),
      .rnd_rd_en    (rnd_rd_en),
      .cand_data    (cand_data),
      .cand_valid   (cand_valid),
      .cand_ready   (cand_ready),
      .rejected_cnt (rejected_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every handshake transfer must match the oldest queued candidate
   always @(negedge clk) begin
      if (aresetn && cand_valid && cand_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cand", {16'd0, cand_data}, 32'hFFFF_FFFF);
         end else begin
            chk("cand_data", {16'd0, cand_data}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   // One word through the block with cand_ready high; checks pop, valid timing, count
   task automatic run_vec(input logic [W-1:0] w, input logic [W-1:0] c, input bit rej);
      int vcyc;
      int exp_vcyc;
      @(posedge clk); #1;
      rnd_data  = w;
      rnd_empty = 1'b0;
      @(negedge clk);
      chk("pop", {31'd0, rnd_rd_en}, 32'd1);
      if (SIEVE && rej) exp_rej++;
      else exp_q.push_back(c);
      @(posedge clk); #1;
      rnd_empty = 1'b1;
      vcyc = -1;
      for (int k = 1; k <= W + 5; k++) begin
         @(negedge clk);
         if (cand_valid && vcyc < 0) vcyc = k;
      end
      exp_vcyc = (SIEVE && rej) ? -1 : LAT;
      chk("valid_cycle", vcyc, exp_vcyc);
      chk("rej_cnt", {16'd0, rejected_cnt}, exp_rej);
   endtask

   initial begin
      int bad;
      int pcyc;
      logic [W-1:0] held;
      aresetn    = 1'b0;
      rnd_data   = '0;
      rnd_empty  = 1'b1;
      cand_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rd_en", {31'd0, rnd_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, cand_valid}, 32'd0);
      chk("rst_data", {16'd0, cand_data}, 32'd0);
      chk("rst_rej", {16'd0, rejected_cnt}, 32'd0);
      aresetn = 1'b1;

      // Directed vectors: survivors and composites (factor 3 and factor 59)
      run_vec(16'h0002, 16'h8003, 1'b0);
      run_vec(16'h7FFE, 16'hFFFF, 1'b1);
      run_vec(16'h005E, 16'h805F, 1'b1);
      run_vec(16'h7FF0, 16'hFFF1, 1'b0);

      // Rejected word followed by an available word: time the next pop
      @(posedge clk); #1;
      rnd_data  = 16'h7FFE;
      rnd_empty = 1'b0;
      @(negedge clk);
      chk("rej_pop", {31'd0, rnd_rd_en}, 32'd1);
      if (SIEVE) exp_rej++;
      else exp_q.push_back(16'hFFFF);
      @(posedge clk); #1;
      rnd_data = 16'h0002;
      pcyc = -1;
      bad  = 0;
      for (int k = 1; k <= 40 && pcyc < 0; k++) begin
         @(negedge clk);
         if (rnd_rd_en) begin
            pcyc = k;
            exp_q.push_back(16'h8003);
         end else if (cand_valid && SIEVE) begin
            bad++;
         end
      end
      chk("rej_next_pop_cycle", pcyc, SIEVE ? W + 2 : 2);
      chk("rej_no_valid", bad, 0);
      chk("rej_cnt2", {16'd0, rejected_cnt}, exp_rej);
      @(posedge clk); #1;
      rnd_empty = 1'b1;
      repeat (W + 5) @(negedge clk);

      // Backpressure: hold output for 10 cycles while another word waits
      cand_ready = 1'b0;
      @(posedge clk); #1;
      rnd_data  = 16'h0002;
      rnd_empty = 1'b0;
      @(negedge clk);
      chk("bp_pop", {31'd0, rnd_rd_en}, 32'd1);
      exp_q.push_back(16'h8003);
      @(posedge clk); #1;
      rnd_data = 16'h7FF0;
      pcyc = -1;
      for (int k = 1; k <= 60 && pcyc < 0; k++) begin
         @(negedge clk);
         if (cand_valid) pcyc = k;
      end
      chk("bp_valid_cycle", pcyc, LAT);
      bad  = 0;
      held = cand_data;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!cand_valid || cand_data !== 16'h8003 || rnd_rd_en) bad++;
      end
      chk("bp_hold", bad, 0);
      chk("bp_data", {16'd0, held}, 32'h8003);
      @(posedge clk); #1;
      cand_ready = 1'b1;
      @(negedge clk);
      chk("bp_xfer_no_pop", {31'd0, rnd_rd_en}, 32'd0);
      @(negedge clk);
      chk("bp_next_pop", {31'd0, rnd_rd_en}, 32'd1);
      exp_q.push_back(16'hFFF1);
      @(posedge clk); #1;
      rnd_empty = 1'b1;
      repeat (W + 5) @(negedge clk);

      // Empty FIFO for 50 cycles: no pop, no output
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (rnd_rd_en || cand_valid) bad++;
      end
      chk("empty_idle", bad, 0);

      // Reset mid-operation: in-flight word discarded, outputs at reset values
      cand_ready = 1'b0;
      @(posedge clk); #1;
      rnd_data  = 16'h0002;
      rnd_empty = 1'b0;
      @(negedge clk);
      chk("rstmid_pop", {31'd0, rnd_rd_en}, 32'd1);
      @(posedge clk); #1;
      rnd_data = 16'h7FF0;
      repeat (8) @(negedge clk);
      aresetn = 1'b0;
      exp_rej = 0;
      #1;
      chk("rstmid_rd_en", {31'd0, rnd_rd_en}, 32'd0);
      chk("rstmid_valid", {31'd0, cand_valid}, 32'd0);
      chk("rstmid_data", {16'd0, cand_data}, 32'd0);
      chk("rstmid_rej", {16'd0, rejected_cnt}, 32'd0);
      rnd_empty  = 1'b1;
      cand_ready = 1'b1;
      @(negedge clk);
      aresetn = 1'b1;
      run_vec(16'h0002, 16'h8003, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prime_candidate_gen.md
# prime_candidate_gen

Upstream conditioning and sieve stage for the RSA prime search. Pops raw random words from the RNG FIFO, forces each word to a full-width odd candidate, and rejects it if any of the first 16 odd primes divides it. Surviving candidates are handed over a valid/ready handshake to the prime FIFO, from which `primality_test` draws its Miller-Rabin inputs. Cheap trial division removes most composites before the expensive modular-exponentiation rounds.

## Interface
- `WIDTH`, 512, candidate width in bits; legal values are 16 or more.
- `NUM_SMALL`, 16, number of sieve primes used; legal range 1..16, taken in order from 3,5,7,...,59.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `rnd_data`  in  WIDTH  RNG FIFO output; first-word-fall-through, so it is valid whenever `rnd_empty`=0.
- `rnd_empty`  in  1  RNG FIFO empty.
- `rnd_rd_en`  out  1  RNG FIFO pop, one cycle per consumed word.
- `cand_data`  out  WIDTH  candidate forwarded to the prime FIFO.
- `cand_valid`  out  1  `cand_data` valid.
- `cand_ready`  in  1  prime FIFO can accept.
- `rejected_cnt`  out  16  running count of sieved-out candidates.

## Operation
- Reset values: `rnd_rd_en`=0, `cand_valid`=0, `cand_data`=0, `rejected_cnt`=0; FSM in IDLE.
- States are IDLE, SIEVE, CHECK and OUT.
- IDLE: when `rnd_empty`=0, the block captures `rnd_data | (1<<(WIDTH-1)) | 1` into `cand` and into the shift register, drives `rnd_rd_en`=1 combinationally for that cycle only, clears all remainders and the bit counter, then goes to SIEVE. When `rnd_empty`=1 it stays in IDLE and `rnd_rd_en`=0.
- SIEVE: WIDTH cycles, processing one bit per cycle, MSB first.
  - Each lane i computes t = 2*r_i + bit; r_i <= (t >= p_i) ? t - p_i : t.
  - r_i is 6 bits and t is 7 bits.
  - The shift register shifts left by one each cycle.
  - The bit counter ends at WIDTH-1, then the FSM goes to CHECK.
- CHECK: one cycle.
  - If any r_i == 0 the candidate is rejected: `rejected_cnt` += 1 (wraps at 0xFFFF to 0) and the FSM returns to IDLE.
  - Otherwise `cand_data` <= `cand`, `cand_valid` <= 1, and the FSM goes to OUT.
  - Because the MSB is forced and WIDTH >= 16, the candidate always exceeds 59, so r_i == 0 always means composite.
- OUT: `cand_valid` and `cand_data` hold steady until `cand_ready`=1. On that transfer cycle `cand_valid` <= 0 and the FSM returns to IDLE.
- No new word is popped while in SIEVE, CHECK or OUT. At most one candidate is in flight.
- Asserting `aresetn` low mid-operation immediately drops `cand_valid` and `rnd_rd_en`, discards the in-flight word (it has already been popped) and restores all reset values.

## Timing
- Word accepted (pop) at cycle 0.
- SIEVE runs on cycles 1..WIDTH.
- CHECK is on cycle WIDTH+1.
- `cand_valid` first high at cycle WIDTH+2.
- Rejected words: next pop no earlier than cycle WIDTH+2.
- After a transfer at cycle T, the next pop is no earlier than cycle T+1.
- `cand_ready` is sampled only in OUT. Setting `cand_ready` high early has no effect.
- Throughput is at most one candidate per WIDTH+3 cycles.

## Configuration
- `PRIME_SIEVE_EN` defined: full sieve as described above.
- `PRIME_SIEVE_EN` undefined:
  - SIEVE, CHECK and the remainder lanes are not built.
  - IDLE goes directly to OUT, so `cand_valid` is high at cycle 1 for every popped word.
  - `rejected_cnt` is tied to 0.
  - Conditioning (MSB and LSB forced to 1) is still applied.

## Structure
- Shared package `rsa_pkg` holds:
  - the state enum;
  - the constant array `SMALL_PRIMES[0:15]` = 3..59;
  - `REM_W`=6.
- Sub-module `small_prime_rem` is one remainder lane, with inputs clk, rst, clear, enable, bit and constant p, and output rem. It is instantiated NUM_SMALL times in a generate loop.

## Test plan
- WIDTH=16, RNG word 0x0002: candidate 0x8003 (32771, no small factor). `rnd_rd_en` pulses at cycle 0, `cand_valid` rises at cycle 18 with `cand_data`=0x8003, `rejected_cnt`=0.
- WIDTH=16, RNG word 0x7FFE: candidate 0xFFFF (divisible by 3) is rejected. `cand_valid` stays 0, `rejected_cnt`=1, and the next pop occurs when the FIFO is non-empty at cycle 18 or later.
- Backpressure: 0x0002 with `cand_ready`=0 for 10 cycles. `cand_valid` and `cand_data`=0x8003 hold steady, with no second pop until the transfer completes.
- Empty FIFO: `rnd_empty`=1 for 50 cycles gives `rnd_rd_en`=0 throughout, and the FSM stays in IDLE.
- Reset mid-SIEVE: `aresetn` low at cycle 8 after a pop gives all outputs at reset values immediately. After release, the next word is processed normally from cycle 0.
- `PRIME_SIEVE_EN` undefined, word 0x7FFE: `cand_valid` high at cycle 1 with `cand_data`=0xFFFF, `rejected_cnt`=0.
